uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single serial transmitter behind the chip-level `TXD` pin between `NREQ` byte requesters: CPU MMIO console writes, debug trace, and later sources. Each requester presents a byte with a level request. The block grants one requester at a time in round-robin order, acknowledges it, and serializes the byte as a UART 8N1 frame. It sits between the `selevy` core's peripheral logic and the `TXD` output pin.

## Interface
- `NREQ`, 2: number of requesters, 1..8.
- `CLKS_PER_BIT`, 868: `CLK` cycles per bit (100 MHz / 115200 baud); must be at least 2.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `req`  in  NREQ  per-requester level request; bit i belongs to requester i.
- `data`  in  8*NREQ  byte i is at `data[8*i+7:8*i]`; must be stable while `req[i]` is high.
- `ack`  out  NREQ  one-cycle pulse: requester i's byte has been latched.
- `busy`  out  1  high while a frame is on the line.
- `TXD`  out  1  serial output, idle high.

## Operation
- Two states.
  - IDLE: `busy`=0, `TXD`=1.
  - SEND: a frame is in progress.
- IDLE → SEND: when any `req` bit is high at a clock edge.
  - Winner: the first set bit scanning upward from `rr_ptr`, wrapping modulo `NREQ`.
  - On that edge: latch the winner's byte, set `ack[winner]`=1 for exactly one cycle, set `busy`=1, start the start bit (`TXD`=0).
  - Set `rr_ptr` = (winner+1) mod `NREQ`.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles, so a frame is 10×`CLKS_PER_BIT` cycles.
- SEND → IDLE: on the edge ending the stop bit.
- Requester rules:
  - Hold `req` and `data` until `ack` is seen.
  - In the `ack` cycle or later, drop `req` or present the next byte with `req` still high. That byte enters the next arbitration round.
  - Dropping `req` before `ack` is legal; that byte is not sent.
- `req` changes during SEND are ignored; arbitration happens only in IDLE.
- Only one `ack` bit is ever high, and never while in IDLE.
- Reset values: state IDLE, `TXD`=1, `busy`=0, `ack`=0, `rr_ptr`=0, counters 0.
- Reset during SEND: the frame is abandoned. `TXD`=1 from the edge after reset is sampled. No further `ack` is issued.
- With `NREQ`=1 the block degenerates to a single-source transmitter; `rr_ptr` is constant 0.

## Timing
- Latency: `req` sampled high in IDLE at edge k → `ack` and `TXD`=0 in cycle k+1.
- Start bit: cycles k+1 .. k+`CLKS_PER_BIT`.
- Data bit n (n = 0..7): starts at cycle k+1+(n+1)×`CLKS_PER_BIT`.
- Stop bit ends at cycle k+10×`CLKS_PER_BIT`; the block is IDLE in cycle k+10×`CLKS_PER_BIT`+1.
- Back-to-back frames have exactly 1 idle-high cycle between the stop bit and the next start bit.
- `busy` is high for exactly 10×`CLKS_PER_BIT` cycles per frame.
- Counters:
  - Baud counter: width clog2(`CLKS_PER_BIT`); counts 0..`CLKS_PER_BIT`-1 and wraps.
  - Bit counter: 4 bits, 0..9.
  - No other arithmetic.
- `TXD` is driven directly from a flop; no combinational path from inputs to `TXD`.

## Structure
- Shared package `uart_pkg`:
  - `UART_FRAME_BITS`=10.
  - `UART_DATA_BITS`=8.
  - Default `CLKS_PER_BIT` constant.
  - State encoding constants `ARB_IDLE`, `ARB_SEND`.
- Sub-module `uart_tx_shifter`:
  - Inputs: `CLK`, `reset`, `start`, `din[7:0]`.
  - Outputs: `TXD`, `done` (pulse on the last cycle of the stop bit).
  - Owns the baud counter, bit counter and 10-bit shift register.
  - Reusable by any later standalone UART.
- Top level `uart_tx_arbiter`: state register, round-robin pointer, priority scan, `ack` register.

## Test plan
- Reset hold: `reset`=1 for 2 edges with `req`=2'b11 → `TXD`=1, `busy`=0, `ack`=0 throughout; first `ack` one cycle after reset deasserts.
- Single byte: `CLKS_PER_BIT`=4, `req[0]`=1, byte 0x55 → `ack`=2'b01 one cycle. `TXD` sequence per 4 cycles is 0,1,0,1,0,1,0,1,0,1. `busy` high for 40 cycles.
- Contention: `req`=2'b11 held, bytes 0xA0 / 0x0B → frames go 0xA0, 0x0B, 0xA0, 0x0B. Each pair of frames is separated by exactly 1 idle cycle; `ack` alternates.
- Withdrawal: `req[1]` pulsed for 1 cycle during a requester-0 frame → no `ack[1]`, no frame for requester 1.
- Reset mid-frame: assert `reset` during data bit 3 → `TXD`=1 on the next edge. After release, a new `req[1]` with 0x3C transmits cleanly and `rr_ptr` restarts at 0.
- Ack rules: in every test, `ack` is one-hot or zero, never asserted in IDLE, and every `ack` is followed by exactly one well-formed frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and the arbiter state encoding.
// Imported by the transmit shifter and the requester arbiter.
package uart_pkg;

   localparam int UART_FRAME_BITS   = 10;
   localparam int UART_DATA_BITS    = 8;
   localparam int UART_CLKS_PER_BIT = 868;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_SEND = 1'b1
   } arb_state_e;

endpackage

// File: rtl/uart_tx_shifter.sv
// UART 8N1 frame serializer: start bit, 8 data bits LSB first, stop bit.
// TXD is bit 0 of the frame shift register, so it comes straight from a flop.
module uart_tx_shifter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic                      CLK,
   input  logic                      reset,
   input  logic                      start,
   input  logic [UART_DATA_BITS-1:0] din,
   output logic                      TXD,
   output logic                      done
);

   localparam int              BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]      BIT_LAST  = 4'(UART_FRAME_BITS - 1);

   logic                       active_q;
   logic [BW-1:0]              baud_q;
   logic [3:0]                 bit_q;
   logic [UART_FRAME_BITS-1:0] shift_q;
   logic                       bit_end;

   assign bit_end = active_q && (baud_q == BAUD_LAST);
   assign done    = bit_end && (bit_q == BIT_LAST);
   assign TXD     = shift_q[0];

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (reset) begin
         active_q <= 1'b0;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '1;
      end else if (start && !active_q) begin
         active_q <= 1'b1;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= {1'b1, din, 1'b0};
      end else if (active_q) begin
         if (bit_end) begin
            baud_q  <= '0;
            // Ones shift in from the top, so the line rests high once the stop bit ends.
            shift_q <= {1'b1, shift_q[UART_FRAME_BITS-1:1]};
            if (done) begin
               active_q <= 1'b0;
               bit_q    <= '0;
            end else begin
               bit_q <= bit_q + 4'd1;
            end
         end else begin
            baud_q <= baud_q + BW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters.
// Arbitration happens only while idle; the winner is acked and its byte serialized.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ         = 2,
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic                         CLK,
   input  logic                         reset,
   input  logic [NREQ-1:0]              req,
   input  logic [UART_DATA_BITS*NREQ-1:0] data,
   output logic [NREQ-1:0]              ack,
   output logic                         busy,
   output logic                         TXD
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_e                state_q;
   logic [PW-1:0]             rr_ptr_q;
   logic [PW-1:0]             rr_ptr_d;
   logic [NREQ-1:0]           ack_q;
   logic                      busy_q;

   logic                      found;
   logic [PW-1:0]             winner;
   logic [NREQ-1:0]           win_onehot;
   logic [UART_DATA_BITS-1:0] win_byte;
   logic                      start;
   logic                      done;
   int                        scan_idx;

   // NOTE: every signal written here gets a default first, so no path through
   // the loop can leave a value held and infer a latch.
   always_comb begin
      found      = 1'b0;
      winner     = '0;
      win_onehot = '0;
      win_byte   = '0;
      scan_idx   = 0;
      for (int off = 0; off < NREQ; off++) begin
         scan_idx = int'(rr_ptr_q) + off;
         if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
         if (!found && req[scan_idx]) begin
            found                = 1'b1;
            winner               = PW'(scan_idx);
            win_onehot[scan_idx] = 1'b1;
            win_byte             = data[UART_DATA_BITS*scan_idx +: UART_DATA_BITS];
         end
      end
   end

   assign rr_ptr_d = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
   assign start    = (state_q == ARB_IDLE) && found;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
         ack_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         ack_q <= '0;
         unique case (state_q)
            ARB_IDLE: begin
               if (found) begin
                  state_q  <= ARB_SEND;
                  busy_q   <= 1'b1;
                  ack_q    <= win_onehot;
                  rr_ptr_q <= rr_ptr_d;
               end
            end
            ARB_SEND: begin
               if (done) begin
                  state_q <= ARB_IDLE;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign ack  = ack_q;
   assign busy = busy_q;

   uart_tx_shifter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_shifter (
      .CLK   (CLK),
      .reset (reset),
      .start (start),
      .din   (win_byte),
      .TXD   (TXD),
      .done  (done)
   );

endmodule
